// File: rtl/sr_frame_ctrl.sv
// sr_frame_ctrl
//   Frame controller that owns a WIDTH-bit shift register and sequences
//   capture frames (serial x -> parallel word) and transmit frames (parallel
//   din -> serial sout, MSB first). Every frame shifts x into the LSB, so the
//   completed word is always the WIDTH bits of x seen during SHIFT.
//
//   Completed-frame handshake: dout_valid is high for the whole HOLD state
//   and dout/dout_mode are stable while it is high. A frame is consumed on
//   the rising edge where dout_valid and dout_ack are both high; dout_ack at
//   any other time has no effect. A consumed frame bumps frames_done.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        frame request (taken in IDLE, or in HOLD together with dout_ack)
//   mode         0 = capture, 1 = transmit; sampled with start
//   din          parallel word for transmit; sampled with start
//   x            serial input, shifted into the LSB on every SHIFT edge
//   abort        synchronous cancel back to IDLE (beats start and dout_ack)
//   dout_ack     consumer acknowledge of dout
//   busy         high in SHIFT
//   sout         sr[WIDTH-1] in SHIFT, 0 otherwise
//   sr_out       live shift register contents
//   dout         completed frame word
//   dout_valid   high in HOLD
//   dout_mode    mode of the frame held in dout
//   frames_done  acknowledged-frame counter, wraps modulo 2^CNT_W
//   fsm_state    current FSM state encoding (0 IDLE, 1 SHIFT, 2 HOLD)

module sr_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    input  logic             x,
    input  logic             abort,
    input  logic             dout_ack,
    output logic             busy,
    output logic             sout,
    output logic [WIDTH-1:0] sr_out,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_mode,
    output logic [CNT_W-1:0] frames_done,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_mode_q, dout_mode_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    logic [WIDTH-1:0] sr_shift;
    logic             load_frame;

    assign sr_shift = {sr_q[WIDTH-2:0], x};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            dout_q      <= '0;
            dout_mode_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            dout_q      <= dout_d;
            dout_mode_q <= dout_mode_d;
            frames_q    <= frames_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        dout_d      = dout_q;
        dout_mode_d = dout_mode_q;
        frames_d    = frames_q;
        load_frame  = 1'b0;

        if (abort) begin
            // dout and the counter are left alone: an aborted frame never
            // reaches the consumer and is never counted.
            state_d = ST_IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    load_frame = start;
                end
                ST_SHIFT: begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_HOLD;
                        cnt_d       = '0;
                        dout_d      = sr_shift;
                        dout_mode_d = mode_q;
                    end
                end
                ST_HOLD: begin
                    if (dout_ack) begin
                        frames_d = frames_q + 1'b1;
                        state_d  = ST_IDLE;
                        // Acknowledge plus start chains straight into the
                        // next frame without an IDLE cycle.
                        load_frame = start;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (load_frame) begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
                mode_d  = mode;
                sr_d    = mode ? din : '0;
            end
        end
    end

    assign busy        = (state_q == ST_SHIFT);
    assign sout        = busy ? sr_q[WIDTH-1] : 1'b0;
    assign sr_out      = sr_q;
    assign dout        = dout_q;
    assign dout_valid  = (state_q == ST_HOLD);
    assign dout_mode   = dout_mode_q;
    assign frames_done = frames_q;
    assign fsm_state   = state_q;

endmodule

// File: doc/sr_frame_ctrl.md
Name: sr_frame_ctrl

Overview:
- Frame controller that owns and sequences a WIDTH-bit shift register.
- Capture mode: assembles WIDTH serial bits from x into a parallel word.
- Transmit mode: loads a parallel word and shifts it out MSB-first on sout.
- Completed frames go out on a valid/ack handshake; a wrapping frame counter supports bring-up and lab observation.

Parameters:
- WIDTH, 4: shift register length and bits per frame; legal range ≥2.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  frame request; sampled only in IDLE, or in HOLD together with dout_ack.
- mode  input  1  sampled with start; 0 = capture, 1 = transmit.
- din  input  WIDTH  parallel word for transmit; sampled with start.
- x  input  1  serial data in; shifted into the LSB on every SHIFT edge, in both modes.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- dout_ack  input  1  consumer acknowledge of dout.
- busy  output  1  high in SHIFT.
- sout  output  1  serial out; equals sr[WIDTH-1] in SHIFT, 0 otherwise.
- sr_out  output  WIDTH  live shift register contents.
- dout  output  WIDTH  completed frame word; stable while dout_valid is high.
- dout_valid  output  1  high in HOLD.
- dout_mode  output  1  mode of the frame held in dout.
- frames_done  output  CNT_W  count of acknowledged frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, sr=0, cnt=0, dout=0, dout_valid=0, dout_mode=0, busy=0, sout=0, frames_done=0. Deassertion takes effect at the next rising edge.
- Internal shift step: sr <= {sr[WIDTH-2:0], x}, i.e. shift left with the new bit entering the LSB.
- States: IDLE, SHIFT, HOLD. The state is registered.
- IDLE:
  - start=1 at edge E0 -> SHIFT, cnt=0, latch frame mode.
  - sr <= din if mode=1, sr <= 0 if mode=0.
  - start=0 -> remain in IDLE; sr holds its value.
- SHIFT:
  - One shift step per edge; cnt increments.
  - At the edge where cnt==WIDTH-1 (edge E_WIDTH): perform the shift, go to HOLD, dout <= post-shift sr, dout_mode <= latched mode, dout_valid=1.
  - start is ignored in SHIFT.
- Latency: dout_valid rises exactly WIDTH+1 rising edges after E0, counting E0.
- Capture result: dout = {x@E1, x@E2, ..., x@E_WIDTH}, with the x sampled at E1 in the MSB.
- Transmit sequence: sout = din[WIDTH-1] between E0 and E1, din[WIDTH-2] between E1 and E2, ..., din[0] between E_(WIDTH-1) and E_WIDTH.
- HOLD:
  - dout and dout_valid hold until dout_ack=1.
  - dout_ack=1, start=0 -> IDLE, dout_valid=0, frames_done+1.
  - dout_ack=1, start=1 -> back-to-back frame: frames_done+1, go directly to SHIFT with the IDLE load rules, dout_valid=0 in the next cycle.
  - start without dout_ack is ignored.
- dout_ack outside HOLD: ignored.
- abort=1 (priority over start/ack): next edge -> IDLE, sr=0, cnt=0, dout_valid=0. dout and frames_done are unchanged; an aborted frame is never counted.
- frames_done at 2^CNT_W-1 plus an ack wraps to 0.
- Reset asserted mid-SHIFT or mid-HOLD: immediate return to the reset values; the partial frame is lost.
- No X propagation: every register has a defined reset value.

Test Plan:
- WIDTH=4, capture: reset low for 50 ns then high; start=1, mode=0 for one cycle; x=1,0,1,1 at E1..E4 -> dout_valid rises after E4, dout=4'b1011, dout_mode=0, busy high for exactly 4 cycles.
- Transmit: start, mode=1, din=4'b1100 -> sout=1,1,0,0 across the 4 SHIFT cycles; dout=4'b0000 with x=0; dout_ack -> frames_done=1.
- Back-to-back: in HOLD, assert dout_ack+start with mode=0 in the same cycle -> no IDLE cycle, busy next cycle, frames_done increments once, second capture of x=0,1,1,0 gives dout=4'b0110.
- Abort after E2 of a capture -> IDLE next edge, sr_out=0, dout_valid stays 0, frames_done unchanged; start pulses during SHIFT have no effect.
- Async reset pulled low mid-HOLD (between edges) -> dout_valid, sr_out, frames_done drop to 0 immediately, without waiting for a clock edge.
- CNT_W=2: complete 4 acknowledged frames -> frames_done sequence 1,2,3,0.
